// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the IF and ID stages.
// Holds the architectural width, the NOP encoding and the fetch-packet type.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage : pipe_pkg

// File: rtl/prefetch_ram.sv
// DEPTH x DW storage for the prefetch queue.
// One synchronous write port and one asynchronous (combinational) read port.
module prefetch_ram #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy lives in the pointer/count logic,
  // so stale words are never presented as valid and a reset would only cost flops.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : prefetch_ram

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue between IF and ID: circular FIFO of {pc, instr}.
// Optional zero-latency bypass on an empty queue when IF_PREFETCH_BYPASS_EN is defined.
module if_prefetch_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_pc,
  input  logic [W-1:0]             in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_pc,
  output logic [W-1:0]             out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     state_q, state_d;

  logic           head_valid;
  logic           bypass_take;
  logic           do_push;
  logic           do_pop;
  logic [2*W-1:0] head_pkt;
  logic [W-1:0]   head_pc;
  logic [W-1:0]   head_instr;

  prefetch_ram #(
    .DEPTH (DEPTH),
    .DW    (2 * W)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc, in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_pkt)
  );

  assign {head_pc, head_instr} = head_pkt;

  // Flush masks both handshakes, which is what gives it priority over push and pop.
  assign in_ready   = (state_q != ST_FULL) && !flush;
  assign head_valid = (state_q != ST_EMPTY) && !flush;

`ifdef IF_PREFETCH_BYPASS_EN
  logic bypass_active;

  assign bypass_active = (state_q == ST_EMPTY) && in_valid && !flush;
  assign bypass_take   = bypass_active && out_ready;
  assign out_valid     = head_valid || bypass_active;

  always_comb begin
    out_pc    = '0;
    out_instr = W'(NOP_INSTR);
    if (head_valid) begin
      out_pc    = head_pc;
      out_instr = head_instr;
    end else if (bypass_active) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign out_valid   = head_valid;
  assign out_pc      = head_valid ? head_pc : '0;
  assign out_instr   = head_valid ? head_instr : W'(NOP_INSTR);
`endif

  // A bypassed instruction that decode takes immediately never enters the queue.
  assign do_push = in_valid && in_ready && !bypass_take;
  assign do_pop  = head_valid && out_ready;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = ST_PARTIAL;
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = ST_FULL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign count = count_q;

endmodule : if_prefetch_buffer

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: directed vector table, hand sequences
// and randomized traffic compared against a queue-based reference model.
module tb_if_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pc;
  logic [W-1:0]  in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instr;
  logic          flush;
  logic [CW-1:0] count;

  if_prefetch_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: an ordered list of queued packets ----------------
  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } pkt_t;

  pkt_t ref_q[$];
  bit   model_ok = 1'b0;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic bit m_bypass();
    return BYP && (ref_q.size() == 0) && in_valid && !flush;
  endfunction

  task automatic check_model();
    bit           ev;
    logic [W-1:0] epc;
    logic [W-1:0] ein;
    if (!model_ok) return;
    ev  = 1'b0;
    epc = '0;
    ein = '0;
    if (!flush && ref_q.size() != 0) begin
      ev  = 1'b1;
      epc = ref_q[0].pc;
      ein = ref_q[0].instr;
    end else if (m_bypass()) begin
      ev  = 1'b1;
      epc = in_pc;
      ein = in_instr;
    end
    check("model out_valid", out_valid, ev);
    check("model out_pc", out_pc, epc);
    check("model out_instr", out_instr, ein);
    check("model in_ready", in_ready, (ref_q.size() < DEPTH) && !flush);
    check("model count", count, ref_q.size());
  endtask

  task automatic model_edge();
    bit   push;
    bit   pop;
    pkt_t p;
    if (reset) begin
      ref_q.delete();
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    if (flush) begin
      ref_q.delete();
      return;
    end
    if (m_bypass() && out_ready) return;
    pop  = (ref_q.size() != 0) && out_ready;
    push = in_valid && (ref_q.size() < DEPTH);
    if (pop) void'(ref_q.pop_front());
    if (push) begin
      p.pc    = in_pc;
      p.instr = in_instr;
      ref_q.push_back(p);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input bit rst, input bit iv, input logic [W-1:0] pc,
                       input logic [W-1:0] ins, input bit ordy, input bit fl);
    reset     = rst;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           rst;
    bit           iv;
    logic [W-1:0] pc;
    bit           ordy;
    bit           fl;
    bit           chk;
    int           cnt;
    bit           ov;
    logic [W-1:0] opc;
    bit           ird;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] popped[$];

  task automatic add(input bit rst, input bit iv, input logic [W-1:0] pc, input bit ordy,
                     input bit fl, input bit chk, input int cnt, input bit ov,
                     input logic [W-1:0] opc, input bit ird);
    vec_t v;
    v.rst = rst; v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl; v.chk = chk;
    v.cnt = cnt; v.ov = ov; v.opc = opc; v.ird = ird;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;

    //   rst iv  pc       ordy fl  chk cnt ov   opc                      ird
    add(1, 0, 32'h0,   0, 0, 0, 0, 0,   32'h0,                   1);  // reset, state unknown
    add(1, 0, 32'h0,   0, 0, 1, 0, 0,   32'h0,                   1);
    add(0, 0, 32'h0,   0, 0, 1, 0, 0,   32'h0,                   1);  // idle after reset
    add(0, 1, 32'h0,   0, 0, 1, 0, BYP, 32'h0,                   1);  // fill while frozen
    add(0, 1, 32'h4,   0, 0, 1, 1, 1,   32'h0,                   1);
    add(0, 1, 32'h8,   0, 0, 1, 2, 1,   32'h0,                   1);
    add(0, 1, 32'hC,   0, 0, 1, 3, 1,   32'h0,                   1);
    add(0, 1, 32'h10,  0, 0, 1, 4, 1,   32'h0,                   0);  // 5th push refused
    add(0, 0, 32'h0,   1, 0, 1, 4, 1,   32'h0,                   0);  // drain in order
    add(0, 0, 32'h0,   1, 0, 1, 3, 1,   32'h4,                   1);
    add(0, 0, 32'h0,   1, 0, 1, 2, 1,   32'h8,                   1);
    add(0, 0, 32'h0,   1, 0, 1, 1, 1,   32'hC,                   1);
    add(0, 0, 32'h0,   0, 0, 1, 0, 0,   32'h0,                   1);
    add(0, 1, 32'h20,  0, 0, 1, 0, BYP, BYP ? 32'h20 : 32'h0,    1);  // refill
    add(0, 1, 32'h24,  0, 0, 1, 1, 1,   32'h20,                  1);
    add(0, 1, 32'h28,  0, 0, 1, 2, 1,   32'h20,                  1);
    add(0, 1, 32'h2C,  0, 0, 1, 3, 1,   32'h20,                  1);
    add(0, 1, 32'h30,  1, 0, 1, 4, 1,   32'h20,                  0);  // full: pop, push refused
    add(0, 0, 32'h0,   0, 0, 1, 3, 1,   32'h24,                  1);
    add(0, 1, 32'h40,  1, 1, 1, 3, 0,   32'h0,                   0);  // flush with push
    add(0, 0, 32'h0,   1, 0, 1, 0, 0,   32'h0,                   1);
    add(0, 0, 32'h0,   1, 0, 1, 0, 0,   32'h0,                   1);
    add(0, 1, 32'h50,  0, 0, 1, 0, BYP, BYP ? 32'h50 : 32'h0,    1);
    add(0, 0, 32'h0,   0, 0, 1, 1, 1,   32'h50,                  1);
    add(1, 0, 32'h0,   0, 0, 1, 1, 1,   32'h50,                  1);  // reset mid-operation
    add(0, 0, 32'h0,   1, 0, 1, 0, 0,   32'h0,                   1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].pc, instr_of(vecs[i].pc), vecs[i].ordy, vecs[i].fl);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d count", i), count, vecs[i].cnt);
        check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
        check($sformatf("vec%0d out_pc", i), out_pc, vecs[i].opc);
        check($sformatf("vec%0d out_instr", i), out_instr,
              vecs[i].ov ? instr_of(vecs[i].opc) : 32'h0);
        check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].ird);
      end
      check_model();
      tick();
    end

    // Streaming across pointer wrap: one push and one pop per cycle.
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(0, 1, 32'h100 + 32'(4 * i), instr_of(32'h100 + 32'(4 * i)), 1, 0);
      else        drive(0, 0, 32'h0, 32'h0, 1, 0);
      if (i >= 1 && i < 10) check($sformatf("stream%0d count", i), count, BYP ? 0 : 1);
      if (out_valid && out_ready) popped.push_back(out_pc);
      check_model();
      tick();
    end
    check("stream pop count", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      check($sformatf("stream pc%0d", i), popped[i], 32'h100 + 32'(4 * i));

    // Bypass / minimum-latency case on an empty queue.
    drive(0, 1, 32'h200, instr_of(32'h200), 1, 0);
    check("lat0 out_valid", out_valid, BYP);
    check("lat0 out_pc", out_pc, BYP ? 32'h200 : 32'h0);
    check_model();
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0);
    check("lat1 out_valid", out_valid, !BYP);
    check("lat1 out_pc", out_pc, BYP ? 32'h0 : 32'h200);
    check("lat1 count", count, BYP ? 0 : 1);
    check_model();
    tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_prefetch_buffer
